// File: rtl/ras_ckpt_stack.sv
// Return address stack for the fetch predictor: circular storage of return PCs,
// same-cycle push+pop (replace top), checkpoint restore of {index, count}, and
// one-cycle overflow/underflow event pulses.
module ras_ckpt_stack #(
  parameter int unsigned RAS_ENTRIES     = 16,
  parameter int unsigned LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
  parameter int unsigned PC_WIDTH        = 38
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push_valid,
  input  logic [PC_WIDTH-1:0]        push_pc,
  input  logic                       pop_valid,
  input  logic                       restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] restore_index,
  input  logic [LOG_RAS_ENTRIES:0]   restore_count,
  output logic [PC_WIDTH-1:0]        ret_pc,
  output logic                       ret_valid,
  output logic [LOG_RAS_ENTRIES-1:0] ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ras_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CntW = LOG_RAS_ENTRIES + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES-1:0] IdxOne = LOG_RAS_ENTRIES'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [PC_WIDTH-1:0]        mem_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] index_q, index_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;

  logic                       wr_en;
  logic [LOG_RAS_ENTRIES-1:0] wr_addr;
  logic [PC_WIDTH-1:0]        wr_data;

  // Next-state decode: restore beats push/pop; push+pop on a non-empty stack replaces top.
  always_comb begin
    index_d     = index_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = index_q;
    wr_data     = push_pc;
    if (restore_valid) begin
      index_d = restore_index;
      count_d = (restore_count > CntFull) ? CntFull : restore_count;
    end else if (push_valid && pop_valid && (count_q != '0)) begin
      wr_en   = 1'b1;
      wr_addr = index_q;
    end else if (push_valid) begin
      // Also covers push+pop on an empty stack: plain push, no underflow.
      wr_en   = 1'b1;
      wr_addr = index_q + IdxOne;
      index_d = index_q + IdxOne;
      if (count_q < CntFull) begin
        count_d = count_q + CntOne;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop_valid) begin
      if (count_q != '0) begin
        index_d = index_q - IdxOne;
        count_d = count_q - CntOne;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // State and storage update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      index_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
      index_q     <= index_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Outputs are a pure read of registered state; ret_pc may be stale when empty.
  always_comb begin
    ret_pc    = mem_q[index_q];
    ret_valid = (count_q != '0);
    ras_index = index_q;
    ras_count = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed bench for ras_ckpt_stack: a behavioural stack model fills a scoreboard
// queue as each request is driven; entries are popped and compared after the edge.
module tb_ras_ckpt_stack;

  localparam int unsigned N  = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned PW = 38;

  logic          CLK = 1'b0;
  logic          RST;
  logic          push_valid;
  logic [PW-1:0] push_pc;
  logic          pop_valid;
  logic          restore_valid;
  logic [LW-1:0] restore_index;
  logic [LW:0]   restore_count;
  logic [PW-1:0] ret_pc;
  logic          ret_valid;
  logic [LW-1:0] ras_index;
  logic [LW:0]   ras_count;
  logic          overflow;
  logic          underflow;

  ras_ckpt_stack #(
    .RAS_ENTRIES    (N),
    .LOG_RAS_ENTRIES(LW),
    .PC_WIDTH       (PW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .push_valid   (push_valid),
    .push_pc      (push_pc),
    .pop_valid    (pop_valid),
    .restore_valid(restore_valid),
    .restore_index(restore_index),
    .restore_count(restore_count),
    .ret_pc       (ret_pc),
    .ret_valid    (ret_valid),
    .ras_index    (ras_index),
    .ras_count    (ras_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PW-1:0] pc;
    logic          vld;
    logic [LW-1:0] idx;
    logic [LW:0]   cnt;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [PW-1:0] m [N];
  int            mi;
  int            mc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic pv, input logic [PW-1:0] pc,
                      input logic pp, input logic rv, input int ri, input int rc);
    exp_t e;
    logic ovf;
    logic unf;
    RST           = rst;
    push_valid    = pv;
    push_pc       = pc;
    pop_valid     = pp;
    restore_valid = rv;
    restore_index = LW'(ri);
    restore_count = (LW + 1)'(rc);
    ovf = 1'b0;
    unf = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) m[i] = '0;
      mi = 0;
      mc = 0;
    end else if (rv) begin
      mi = ri;
      mc = (rc > N) ? N : rc;
    end else if (pv && pp && mc != 0) begin
      m[mi] = pc;
    end else if (pv) begin
      mi = (mi + 1) % N;
      m[mi] = pc;
      if (mc < N) mc++;
      else ovf = 1'b1;
    end else if (pp) begin
      if (mc > 0) begin
        mi = (mi + N - 1) % N;
        mc--;
      end else begin
        unf = 1'b1;
      end
    end
    e.pc  = m[mi];
    e.vld = (mc != 0);
    e.idx = LW'(mi);
    e.cnt = (LW + 1)'(mc);
    e.ovf = ovf;
    e.unf = unf;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    RST = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, ".ret_pc"},    64'(ret_pc),    64'(e.pc));
    chk({tag, ".ret_valid"}, 64'(ret_valid), 64'(e.vld));
    chk({tag, ".ras_index"}, 64'(ras_index), 64'(e.idx));
    chk({tag, ".ras_count"}, 64'(ras_count), 64'(e.cnt));
    chk({tag, ".overflow"},  64'(overflow),  64'(e.ovf));
    chk({tag, ".underflow"}, 64'(underflow), 64'(e.unf));
  endtask

  task automatic push(input string tag, input logic [PW-1:0] pc);
    step(tag, 1'b0, 1'b1, pc, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; push_valid = 1'b0; push_pc = '0; pop_valid = 1'b0;
    restore_valid = 1'b0; restore_index = '0; restore_count = '0;
    #1;
    step("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    chk("reset.ret_pc_zero", 64'(ret_pc), 64'h0);

    // Basic LIFO
    push("push100", 38'h100);
    push("push200", 38'h200);
    push("push300", 38'h300);
    chk("lifo.top", 64'(ret_pc), 64'h300);
    chk("lifo.idx", 64'(ras_index), 64'd3);
    pop("pop1");
    chk("lifo.pop1", 64'(ret_pc), 64'h200);
    pop("pop2");
    chk("lifo.pop2", 64'(ret_pc), 64'h100);
    pop("pop3");
    chk("lifo.empty", 64'(ret_valid), 64'd0);

    // Underflow from empty
    pop("underflow");
    chk("underflow.pulse", 64'(underflow), 64'd1);
    step("idle_after_unf", 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0);

    // Fill past depth, then drain
    step("reset2", 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    for (int i = 1; i <= 17; i++) push($sformatf("fill%0d", i), PW'(i));
    chk("fill.ovf", 64'(overflow), 64'd1);
    chk("fill.cnt", 64'(ras_count), 64'd16);
    chk("fill.idx", 64'(ras_index), 64'd1);
    chk("fill.top", 64'(ret_pc), 64'd17);
    for (int i = 1; i <= 15; i++) pop($sformatf("drain%0d", i));
    chk("drain15.top", 64'(ret_pc), 64'd2);
    pop("drain16");
    chk("drain16.top", 64'(ret_pc), 64'd17);
    chk("drain16.cnt", 64'(ras_count), 64'd0);

    // Same-cycle push+pop
    push("pushA", 38'hA);
    step("replaceB", 1'b0, 1'b1, 38'hB, 1'b1, 1'b0, 0, 0);
    chk("replace.top", 64'(ret_pc), 64'hB);
    chk("replace.cnt", 64'(ras_count), 64'd1);
    pop("emptyagain");
    step("pushpop_empty", 1'b0, 1'b1, 38'hC, 1'b1, 1'b0, 0, 0);
    chk("pushpop_empty.unf", 64'(underflow), 64'd0);
    chk("pushpop_empty.cnt", 64'(ras_count), 64'd1);

    // Checkpoint restore
    step("reset3", 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    push("ck10", 38'h10);
    push("ck20", 38'h20);
    push("ck30", 38'h30);
    pop("ckpop1");
    pop("ckpop2");
    step("restore22", 1'b0, 1'b0, '0, 1'b0, 1'b1, 2, 2);
    chk("restore.top", 64'(ret_pc), 64'h20);
    step("restore_vs_push", 1'b0, 1'b1, 38'h99, 1'b0, 1'b1, 2, 2);
    chk("restore_vs_push.top", 64'(ret_pc), 64'h20);
    step("restore_clamp", 1'b0, 1'b0, '0, 1'b1, 1'b1, 5, 31);
    chk("restore_clamp.cnt", 64'(ras_count), 64'd16);

    // Wrap of pop from index 0
    step("restore_idx0", 1'b0, 1'b0, '0, 1'b0, 1'b1, 0, 3);
    pop("pop_wrap");
    chk("pop_wrap.idx", 64'(ras_index), 64'd15);

    // Reset during a push
    step("reset4", 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    for (int i = 1; i <= 5; i++) push($sformatf("pre%0d", i), PW'(i * 16));
    step("rst_with_push", 1'b1, 1'b1, 38'h55, 1'b0, 1'b0, 0, 0);
    chk("rst_with_push.pc", 64'(ret_pc), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ckpt_stack.md
# ras_ckpt_stack

Parametrised return address stack (RAS) for the fetch predictor, generalising the fixed 16-entry RAS to configurable depth and PC width. It adds same-cycle push+pop (call-with-return replace-top), checkpoint restore of {index, count} from the branch checkpoint buffer (BCB), and overflow/underflow event pulses. It sits beside the BTB/PHT lookup path. It supplies the predicted return PC for RET/RET_L actions and exposes its pointer state so the BCB can snapshot it.

## Interface
- RAS_ENTRIES, 16, stack depth; power of 2, ≥2.
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), index width.
- PC_WIDTH, 38, width of a stored return PC (PC38 format).
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset. **Synchronous, active-high; one clock.**
- push_valid  input  1  push push_pc onto the stack.
- push_pc  input  PC_WIDTH  return address to push.
- pop_valid  input  1  pop top of stack.
- restore_valid  input  1  overwrite pointer state from a checkpoint.
- restore_index  input  LOG_RAS_ENTRIES  checkpointed top index.
- restore_count  input  LOG_RAS_ENTRIES+1  checkpointed occupancy.
- ret_pc  output  PC_WIDTH  entry at current top index (combinational from state).
- ret_valid  output  1  count != 0.
- ras_index  output  LOG_RAS_ENTRIES  current top index, for BCB snapshot.
- ras_count  output  LOG_RAS_ENTRIES+1  current occupancy, range 0..RAS_ENTRIES.
- overflow  output  1  one-cycle pulse: push at full overwrote oldest entry.
- underflow  output  1  one-cycle pulse: pop with count==0.

## Operation
- State: mem[RAS_ENTRIES] of PC_WIDTH, index, count, overflow/underflow regs.
- Index points at the current top entry. The stack is circular, and index arithmetic wraps modulo RAS_ENTRIES.
- Priority per cycle: RST > restore_valid > push/pop.
- RST: mem all zero, index=0, count=0, overflow=0, underflow=0.
- restore_valid: index<=restore_index; count<=min(restore_count, RAS_ENTRIES). mem is untouched. push/pop in the same cycle are ignored. overflow=underflow=0.
- Push only: mem[index+1]<=push_pc; index<=index+1.
  - If count<RAS_ENTRIES: count+1.
  - Else: count stays and overflow<=1.
- Pop only:
  - If count>0: index<=index-1, count-1.
  - Else: no state change and underflow<=1.
- Push+pop same cycle (RET_L / coroutine):
  - If count>0: mem[index]<=push_pc; index and count unchanged.
  - If count==0: behaves as push only, with no underflow.
- No request: state holds; overflow=underflow=0.
- ret_pc is mem[index] even when count==0 (stale data). Consumers must qualify it with ret_valid.

## Timing
- All outputs are driven from registers or a combinational read of registered state. There is no input-to-output combinational path.
- Update latency is 1 cycle: a push at edge N makes ret_pc==push_pc visible after edge N.
- overflow/underflow are asserted for exactly the cycle after the offending request edge.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Reset mid-operation: any requests in the RST cycle are discarded; all outputs read reset values the cycle after.
- Restore in the same cycle as push/pop: restore wins and the push data is dropped.
- Wrap-around:
  - Push from index=RAS_ENTRIES-1 goes to 0.
  - Pop from index=0 goes to RAS_ENTRIES-1.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> ret_pc=0x300, ras_index=3, ras_count=3. Then pop three times -> ret_pc sequence 0x200, 0x100, then ret_valid=0, count=0.
- Pop with count=0 -> underflow pulses 1 cycle; index=0 and count=0 unchanged; ret_valid=0.
- Push 17 values 1..17 with RAS_ENTRIES=16:
  - The 17th push pulses overflow; count stays 16.
  - index wraps to 1; ret_pc=17.
  - 15 pops then expose 2; one more pop exposes the overwritten slot's new value 17, with count reaching 0 after 16 pops.
- Push 0xA then simultaneous push 0xB + pop -> ret_pc=0xB, count=1, index unchanged. Simultaneous push+pop with count=0 -> count=1, no underflow.
- Push 0x10, 0x20 and snapshot index=2, count=2. Push 0x30, pop, pop, then restore(2,2) -> ret_pc=0x20 and count=2. Restore with a concurrent push of 0x99 -> push ignored.
- Assert RST during a push of 0x55 with count=5 -> next cycle index=0, count=0, ret_pc=0, flags 0.
